// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. A miss fetches the addressed line
// and the one after it in a single block read, then installs both.

module icache_line #(
  parameter int TAG_BITS  = 25,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 we_i,
  input  logic [TAG_BITS-1:0]  tag_i,
  input  logic [LINE_BITS-1:0] data_i,
  output logic                 valid_o,
  output logic [TAG_BITS-1:0]  tag_o,
  output logic [LINE_BITS-1:0] data_o
);
  logic                 valid_q;
  logic [TAG_BITS-1:0]  tag_q;
  logic [LINE_BITS-1:0] data_q;

  // A fill beats a same-cycle flush for this line.
  always_ff @(posedge clk_i) begin
    if (rst_i)        valid_q <= 1'b0;
    else if (we_i)    valid_q <= 1'b1;
    else if (flush_i) valid_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q  <= tag_i;
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;
endmodule

module icache #(
  parameter int LINE_BITS = 128,
  parameter int LINES     = 8,
  parameter int WORD      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [WORD-1:0]      req_addr_i,
  output logic                 req_ready_o,
  output logic                 resp_valid_o,
  output logic [WORD-1:0]      resp_inst_o,
  input  logic                 flush_i,
  output logic [WORD-1:0]      mem_addr_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_line0_i,
  input  logic [LINE_BITS-1:0] mem_line1_i,
  output logic [15:0]          miss_count_o
);
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int OFF_BITS   = $clog2(LINE_BYTES);
  localparam int IDX_BITS   = $clog2(LINES);
  localparam int TAG_BITS   = WORD - OFF_BITS - IDX_BITS;
  localparam int NWORDS     = LINE_BITS / WORD;
  localparam int WSEL_BITS  = $clog2(NWORDS);
  localparam int BSEL_BITS  = OFF_BITS - WSEL_BITS;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MEM_REQ  = 3'd2;
  localparam logic [2:0] S_MEM_WAIT = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    logic [IDX_BITS-1:0]  idx;
    logic [WSEL_BITS-1:0] wsel;
    logic [BSEL_BITS-1:0] bsel;
  } addr_t;

  logic [2:0] state_q, state_d;
  addr_t      addr_q, addr_d;
  logic [15:0] miss_q, miss_d;

  logic [LINES-1:0]                vld;
  logic [LINES-1:0][TAG_BITS-1:0]  tags;
  logic [LINES-1:0][LINE_BITS-1:0] datas;

  logic [WORD-1:0]     blk_addr, nxt_addr;
  logic [TAG_BITS-1:0] nxt_tag;
  logic [IDX_BITS-1:0] nxt_idx;
  logic                fill, hit;
  logic [NWORDS-1:0][WORD-1:0] cur_line;
  logic [WORD-1:0]     cur_word;
  logic                unused_bits;

  assign blk_addr = {addr_q.tag, addr_q.idx, {OFF_BITS{1'b0}}};
  // Prefetch address wraps at the top of the 32-bit space.
  assign nxt_addr = blk_addr + WORD'(LINE_BYTES);
  assign nxt_tag  = nxt_addr[WORD-1 -: TAG_BITS];
  assign nxt_idx  = nxt_addr[OFF_BITS +: IDX_BITS];
  assign unused_bits = ^{addr_q.bsel, nxt_addr[OFF_BITS-1:0]};

  assign fill = (state_q == S_MEM_WAIT);

  for (genvar g = 0; g < LINES; g++) begin : g_line
    logic sel0, sel1;
    assign sel0 = (addr_q.idx == IDX_BITS'(g));
    assign sel1 = (nxt_idx == IDX_BITS'(g));

    icache_line #(.TAG_BITS(TAG_BITS), .LINE_BITS(LINE_BITS)) u_line (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .we_i    (fill && (sel0 || sel1)),
      .tag_i   (sel0 ? addr_q.tag : nxt_tag),
      .data_i  (sel0 ? mem_line0_i : mem_line1_i),
      .valid_o (vld[g]),
      .tag_o   (tags[g]),
      .data_o  (datas[g])
    );
  end

  assign hit      = vld[addr_q.idx] && (tags[addr_q.idx] == addr_q.tag);
  assign cur_line = datas[addr_q.idx];
  // Word 0 sits in the most significant bits of the line.
  assign cur_word = cur_line[WSEL_BITS'(NWORDS-1) - addr_q.wsel];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    miss_d  = miss_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = addr_t'(req_addr_i);
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP:   state_d = hit ? S_IDLE : S_MEM_REQ;
      S_MEM_REQ: begin
        miss_d  = miss_q + 16'd1;
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      miss_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      miss_q  <= miss_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = ((state_q == S_LOOKUP) && hit) || (state_q == S_RESP);
  assign resp_inst_o  = resp_valid_o ? cur_word : '0;
  assign mem_read_o   = (state_q == S_MEM_REQ);
  assign mem_addr_o   = mem_read_o ? blk_addr : '0;
  assign mem_write_o  = 1'b0;
  assign miss_count_o = miss_q;
endmodule
